branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  EX-stage consumer of the branch comparator's br_en. Resolves branch/JAL/JALR
//  control flow: computes actual target and next PC, checks them against the
//  fetch-stage prediction, and on mispredict drives a held redirect to fetch plus
//  a timed flush of younger stages. Keeps saturating branch/mispredict counters.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles flush_o stays high after redirect_ack (0 = none)
//  CNT_W         16  width of the performance counters
// PORTS
//  clk              in   1      clock; all state updates on rising edge
//  rst              in   1      synchronous, active-high reset
//  valid_i          in   1      EX holds a control-flow instruction this cycle
//  ready_o          out  1      unit can accept; resolve fires on valid_i & ready_o
//  kind_i           in   2      00 none, 01 cond branch, 10 JAL, 11 JALR
//  pc_i             in   32     PC of the instruction
//  imm_i            in   32     sign-extended immediate
//  rs1_i            in   32     rs1 value (JALR base)
//  br_en            in   1      comparator result, same cycle as valid_i
//  pred_taken_i     in   1      fetch predicted taken
//  pred_target_i    in   32     fetch predicted target
//  redirect_valid_o out  1      redirect request to fetch, held until ack
//  redirect_pc_o    out  32     correct next PC
//  redirect_ack_i   in   1      fetch accepted redirect this cycle
//  flush_o          out  1      squash IF/ID younger instructions
//  misalign_o       out  1      one-cycle pulse: taken target[1:0] != 00
//  branch_cnt_o     out  CNT_W  resolved control-flow instructions (saturating)
//  mispred_cnt_o    out  CNT_W  mispredicts (saturating)
// BEHAVIOUR
//  - Reset: state IDLE; ready_o=1, redirect_valid_o=0, redirect_pc_o=0, flush_o=0,
//    misalign_o=0, both counters 0. Reset mid-REDIRECT/DRAIN aborts immediately.
//  - Targets (mod 2^32, carries dropped): branch/JAL tgt=pc_i+imm_i;
//    JALR tgt=(rs1_i+imm_i)&~32'h1. seq=pc_i+4.
//  - taken = (kind==01 & br_en) | kind==10 | kind==11. next = taken ? tgt : seq.
//  - mispredict = (taken != pred_taken_i) | (taken & tgt != pred_target_i).
//  - kind==00 with valid_i: no-op, not counted.
//  - Resolve (IDLE & valid_i & kind!=00): branch_cnt+1; if taken & tgt[1]:
//    misalign_o=1 next cycle, no redirect, mispred_cnt unchanged, stay IDLE.
//    Else if mispredict: mispred_cnt+1, redirect_pc_o<=next, go REDIRECT.
//  - Counters saturate at all-ones; never wrap.
//  - FSM:
//    IDLE:     ready_o=1, flush_o=0. Mispredict resolve -> REDIRECT.
//    REDIRECT: redirect_valid_o=1, flush_o=1, ready_o=0, redirect_pc_o stable.
//              redirect_ack_i -> DRAIN (FLUSH_CYCLES>0) or IDLE (=0);
//              redirect_valid_o drops the cycle after ack.
//    DRAIN:    flush_o=1, ready_o=0, redirect_valid_o=0; counts FLUSH_CYCLES
//              cycles then IDLE.
//  - Latency: resolve in cycle N -> redirect_valid_o/flush_o high in N+1.
//    Ack in cycle M -> last flush cycle M+FLUSH_CYCLES; ready_o=1 at M+FLUSH_CYCLES+1.
//  - valid_i while ready_o=0 is ignored (EX must hold it); ack in IDLE/DRAIN ignored.
//  - Ack in same cycle redirect_valid_o first rises is legal.
// TESTING
//  1 beq, br_en=1, pc=0x100, imm=0x20, pred_taken=0 -> N+1 redirect_pc=0x120,
//    redirect_valid=1, flush=1, mispred_cnt=1.
//  2 bne, br_en=0, pred_taken=0, pc=0x200 -> no redirect, branch_cnt+1, ready stays 1.
//  3 JALR rs1=0x1003, imm=0 -> tgt=0x1002, misalign_o one pulse, no redirect.
//  4 Mispredict, ack held low 5 cycles -> redirect_valid/redirect_pc stable 5 cycles;
//    ack -> flush exactly 2 more cycles (FLUSH_CYCLES=2), then ready_o=1.
//  5 rst asserted in REDIRECT -> next cycle all outputs/counters 0, IDLE.
//  6 CNT_W=4, 20 mispredicts -> mispred_cnt_o holds 4'hF; pc=0xFFFFFFFC imm=8 -> tgt 0x4.

Source files
------------

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : EX-stage branch/JAL/JALR resolution. Computes the actual
//               target and next PC, compares against the fetch prediction
//               and, on a mispredict, holds a redirect request to fetch until
//               it is acknowledged, followed by a timed flush of the younger
//               stages. Keeps saturating branch and mispredict counters.
// Parameters  : FLUSH_CYCLES - cycles flush_o stays high after redirect_ack_i
//               CNT_W        - width of the performance counters
// Ports       : clk, rst            - clock, synchronous active-high reset
//               valid_i / ready_o   - resolve handshake (fires on both high)
//               kind_i              - 00 none, 01 branch, 10 JAL, 11 JALR
//               pc_i, imm_i, rs1_i  - operands for target computation
//               br_en               - branch comparator result
//               pred_taken_i, pred_target_i - fetch-stage prediction
//               redirect_valid_o, redirect_pc_o, redirect_ack_i - fetch redirect
//               flush_o             - squash younger IF/ID instructions
//               misalign_o          - one-cycle pulse on misaligned taken target
//               branch_cnt_o, mispred_cnt_o - saturating counters
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       kind_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      imm_i,
    input  logic [31:0]      rs1_i,
    input  logic             br_en,
    input  logic             pred_taken_i,
    input  logic [31:0]      pred_target_i,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    input  logic             redirect_ack_i,
    output logic             flush_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam logic [1:0] c_KIND_NONE = 2'b00;
    localparam logic [1:0] c_KIND_BR   = 2'b01;
    localparam logic [1:0] c_KIND_JAL  = 2'b10;
    localparam logic [1:0] c_KIND_JALR = 2'b11;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    // Drain counter counts down from FLUSH_CYCLES-1 to 0 while in DRAIN.
    localparam int c_DRAIN_W        = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int c_DRAIN_LOAD_INT = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LOAD = c_DRAIN_W'(c_DRAIN_LOAD_INT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_DRAIN    = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_ready;
    logic                 r_redirect_valid;
    logic [31:0]          r_redirect_pc;
    logic                 r_flush;
    logic                 r_misalign;
    logic [CNT_W-1:0]     r_branch_cnt;
    logic [CNT_W-1:0]     r_mispred_cnt;
    logic [c_DRAIN_W-1:0] r_drain_cnt;

    logic [31:0] w_pc_tgt;
    logic [31:0] w_jalr_tgt;
    logic [31:0] w_tgt;
    logic [31:0] w_seq;
    logic [31:0] w_next;
    logic        w_taken;
    logic        w_mispredict;
    logic        w_misalign;
    logic        w_fire;

    // ------------------------------------------------------------------------
    // Target / outcome computation (all sums wrap mod 2^32)
    // ------------------------------------------------------------------------
    always_comb begin
        w_pc_tgt     = pc_i + imm_i;
        w_jalr_tgt   = (rs1_i + imm_i) & ~32'h1;
        w_tgt        = (kind_i == c_KIND_JALR) ? w_jalr_tgt : w_pc_tgt;
        w_seq        = pc_i + 32'd4;
        w_taken      = ((kind_i == c_KIND_BR) & br_en) |
                       (kind_i == c_KIND_JAL) |
                       (kind_i == c_KIND_JALR);
        w_next       = w_taken ? w_tgt : w_seq;
        w_mispredict = (w_taken != pred_taken_i) |
                       (w_taken & (w_tgt != pred_target_i));
        // A misaligned taken target raises an exception instead of redirecting.
        w_misalign   = w_taken & (w_tgt[1:0] != 2'b00);
        // ready is only high in IDLE, so this is the resolve event.
        w_fire       = valid_i & r_ready & (kind_i != c_KIND_NONE);
    end

    // ------------------------------------------------------------------------
    // Control FSM, counters and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_ready          <= 1'b1;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_flush          <= 1'b0;
            r_misalign       <= 1'b0;
            r_branch_cnt     <= '0;
            r_mispred_cnt    <= '0;
            r_drain_cnt      <= '0;
        end else begin
            r_misalign <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_fire) begin
                        if (r_branch_cnt != c_CNT_MAX) begin
                            r_branch_cnt <= r_branch_cnt + CNT_W'(1);
                        end
                        if (w_misalign) begin
                            r_misalign <= 1'b1;
                        end else if (w_mispredict) begin
                            if (r_mispred_cnt != c_CNT_MAX) begin
                                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
                            end
                            r_redirect_pc    <= w_next;
                            r_redirect_valid <= 1'b1;
                            r_flush          <= 1'b1;
                            r_ready          <= 1'b0;
                            r_state          <= S_REDIRECT;
                        end
                    end
                end

                S_REDIRECT: begin
                    if (redirect_ack_i) begin
                        r_redirect_valid <= 1'b0;
                        if (FLUSH_CYCLES > 0) begin
                            r_drain_cnt <= c_DRAIN_LOAD;
                            r_state     <= S_DRAIN;
                        end else begin
                            r_flush <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_flush <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - c_DRAIN_W'(1);
                    end
                end

                default: begin
                    r_redirect_valid <= 1'b0;
                    r_flush          <= 1'b0;
                    r_ready          <= 1'b1;
                    r_state          <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o          = r_ready;
    assign redirect_valid_o = r_redirect_valid;
    assign redirect_pc_o    = r_redirect_pc;
    assign flush_o          = r_flush;
    assign misalign_o       = r_misalign;
    assign branch_cnt_o     = r_branch_cnt;
    assign mispred_cnt_o    = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Self-checking bench for branch_resolve_unit. Directed
//               scenarios followed by randomized traffic, all compared each
//               cycle against a timeline-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int FC      = 2;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          valid;
    logic          ready;
    logic [1:0]    kind;
    logic [31:0]   pc;
    logic [31:0]   imm;
    logic [31:0]   rs1;
    logic          br_en;
    logic          pred_taken;
    logic [31:0]   pred_target;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          redirect_ack;
    logic          flush;
    logic          misalign;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispred_cnt;

    branch_resolve_unit #(
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_i          (valid),
        .ready_o          (ready),
        .kind_i           (kind),
        .pc_i             (pc),
        .imm_i            (imm),
        .rs1_i            (rs1),
        .br_en            (br_en),
        .pred_taken_i     (pred_taken),
        .pred_target_i    (pred_target),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .redirect_ack_i   (redirect_ack),
        .flush_o          (flush),
        .misalign_o       (misalign),
        .branch_cnt_o     (branch_cnt),
        .mispred_cnt_o    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: a redirect is pending from the cycle after a mispredict
    // resolve until fetch acks it; flush covers the pending window plus FC
    // cycles after the ack cycle. Counters are plain integers clamped at max.
    bit          m_pending = 1'b0;
    int          m_ack_cyc = -1000;
    int          m_mis_cyc = -1;
    int          m_bcnt    = 0;
    int          m_mcnt    = 0;
    logic [31:0] m_rpc     = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit m_flush();
        return m_pending || (cyc <= m_ack_cyc + FC);
    endfunction

    function automatic logic [31:0] ref_target(input logic [1:0] k, input logic [31:0] p,
                                               input logic [31:0] im, input logic [31:0] r1);
        if (k == 2'b11) return (r1 + im) & 32'hFFFF_FFFE;
        return p + im;
    endfunction

    task automatic model_update();
        logic [31:0] tgt;
        logic [31:0] nxt;
        bit          taken;
        bit          mp;
        if (rst) begin
            m_pending = 1'b0;
            m_ack_cyc = -1000;
            m_mis_cyc = -1;
            m_bcnt    = 0;
            m_mcnt    = 0;
            m_rpc     = 32'd0;
            return;
        end
        if (!m_flush() && valid && kind != 2'b00) begin
            m_bcnt = (m_bcnt < CNT_MAX) ? m_bcnt + 1 : CNT_MAX;
            tgt    = ref_target(kind, pc, imm, rs1);
            taken  = (kind == 2'b01) ? br_en : 1'b1;
            nxt    = taken ? tgt : pc + 32'd4;
            if (taken && (tgt % 4) != 0) begin
                m_mis_cyc = cyc + 1;
            end else begin
                mp = (taken != pred_taken) || (taken && tgt != pred_target);
                if (mp) begin
                    m_mcnt    = (m_mcnt < CNT_MAX) ? m_mcnt + 1 : CNT_MAX;
                    m_rpc     = nxt;
                    m_pending = 1'b1;
                end
            end
        end else if (m_pending && redirect_ack) begin
            m_pending = 1'b0;
            m_ack_cyc = cyc;
        end
    endtask

    task automatic check_outputs();
        check("ready",          {31'd0, ready},          {31'd0, !m_flush()});
        check("flush",          {31'd0, flush},          {31'd0, m_flush()});
        check("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_pending});
        check("redirect_pc",    redirect_pc,             m_rpc);
        check("misalign",       {31'd0, misalign},       {31'd0, (m_mis_cyc == cyc)});
        check("branch_cnt",     32'(branch_cnt),         32'(m_bcnt));
        check("mispred_cnt",    32'(mispred_cnt),        32'(m_mcnt));
    endtask

    // Advance one clock: update model with the applied inputs, clock the DUT,
    // then compare all outputs on the falling edge.
    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic set_in(input logic v, input logic [1:0] k, input logic [31:0] p,
                          input logic [31:0] im, input logic [31:0] r1, input logic be,
                          input logic pt, input logic [31:0] ptg, input logic ack);
        valid        = v;
        kind         = k;
        pc           = p;
        imm          = im;
        rs1          = r1;
        br_en        = be;
        pred_taken   = pt;
        pred_target  = ptg;
        redirect_ack = ack;
    endtask

    task automatic idle(input logic ack);
        set_in(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, ack);
    endtask

    initial begin
        rst = 1'b1;
        idle(1'b0);
        tick();
        tick();
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_rv",    {31'd0, redirect_valid}, 32'd0);
        check("reset_flush", {31'd0, flush}, 32'd0);
        rst = 1'b0;

        // 1: taken beq predicted not-taken -> redirect to 0x120
        set_in(1'b1, 2'b01, 32'h100, 32'h20, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
        tick();
        idle(1'b0);
        check("t1_rpc",   redirect_pc, 32'h120);
        check("t1_rv",    {31'd0, redirect_valid}, 32'd1);
        check("t1_flush", {31'd0, flush}, 32'd1);
        check("t1_mcnt",  32'(mispred_cnt), 32'd1);
        idle(1'b1);
        tick();
        idle(1'b0);
        tick();
        tick();
        check("t1_ready", {31'd0, ready}, 32'd1);

        // 2: correctly predicted not-taken bne
        set_in(1'b1, 2'b01, 32'h200, 32'h40, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        idle(1'b0);
        check("t2_rv",    {31'd0, redirect_valid}, 32'd0);
        check("t2_ready", {31'd0, ready}, 32'd1);
        check("t2_bcnt",  32'(branch_cnt), 32'd2);

        // 3: misaligned JALR target 0x1002
        set_in(1'b1, 2'b11, 32'h400, 32'h0, 32'h1003, 1'b0, 1'b1, 32'h1002, 1'b0);
        tick();
        idle(1'b0);
        check("t3_mis", {31'd0, misalign}, 32'd1);
        check("t3_rv",  {31'd0, redirect_valid}, 32'd0);
        tick();
        check("t3_mis_pulse", {31'd0, misalign}, 32'd0);

        // 4: redirect held 5 cycles without ack, then FC flush cycles
        set_in(1'b1, 2'b10, 32'h300, 32'h10, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        idle(1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t4_rv_hold",  {31'd0, redirect_valid}, 32'd1);
            check("t4_rpc_hold", redirect_pc, 32'h310);
            if (i < 4) tick();
        end
        idle(1'b1);
        tick();
        idle(1'b0);
        check("t4_flush1", {31'd0, flush}, 32'd1);
        check("t4_rv_drop", {31'd0, redirect_valid}, 32'd0);
        tick();
        check("t4_flush2", {31'd0, flush}, 32'd1);
        check("t4_busy",   {31'd0, ready}, 32'd0);
        tick();
        check("t4_flush_end", {31'd0, flush}, 32'd0);
        check("t4_ready",     {31'd0, ready}, 32'd1);

        // 5: reset while in REDIRECT
        set_in(1'b1, 2'b10, 32'h500, 32'h8, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        idle(1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rv",    {31'd0, redirect_valid}, 32'd0);
        check("t5_flush", {31'd0, flush}, 32'd0);
        check("t5_rpc",   redirect_pc, 32'd0);
        check("t5_bcnt",  32'(branch_cnt), 32'd0);
        check("t5_ready", {31'd0, ready}, 32'd1);

        // 6: counter saturation and wrapping target
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 2'b10, 32'h1000 + 32'(i * 16), 32'h40, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
            tick();
            idle(1'b1);
            tick();
            idle(1'b0);
            tick();
            tick();
        end
        check("t6_mcnt_sat", 32'(mispred_cnt), 32'hF);
        check("t6_bcnt_sat", 32'(branch_cnt), 32'hF);
        set_in(1'b1, 2'b10, 32'hFFFF_FFFC, 32'h8, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        idle(1'b0);
        check("t6_wrap_rpc", redirect_pc, 32'h4);
        check("t6_mcnt_hold", 32'(mispred_cnt), 32'hF);
        idle(1'b1);
        tick();
        idle(1'b0);
        tick();
        tick();

        // Randomized traffic
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  k;
            logic [31:0] p;
            logic [31:0] im;
            logic [31:0] r1;
            logic [31:0] t;
            logic        be;
            k  = 2'($urandom_range(0, 3));
            p  = $urandom & 32'hFFFF_FFFC;
            im = ($urandom_range(0, 3) != 0) ? ($urandom & 32'hFFFF_FFFC)
                                             : ($urandom & 32'hFFFF_FFFE);
            r1 = $urandom;
            be = 1'($urandom_range(0, 1));
            t  = ref_target(k, p, im, r1);
            set_in(1'($urandom_range(0, 2) != 0), k, p, im, r1, be,
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) != 0) ? t : $urandom,
                   1'($urandom_range(0, 2) == 0));
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
